// File: rtl/gcd_arb_pkg.sv
// Shared constants and types for the two-port GcdUnit request arbiter.
package gcd_arb_pkg;
  localparam int NUM_REQ    = 2;
  localparam int GCD_REQ_W  = 32;
  localparam int GCD_RESP_W = 16;

  typedef logic port_t;

  // Lone requester wins outright; contention goes to the round-robin pointer.
  function automatic port_t rr_pick(input logic [NUM_REQ-1:0] val, input port_t rr);
    case (val)
      2'b01:   rr_pick = 1'b0;
      2'b10:   rr_pick = 1'b1;
      default: rr_pick = rr;
    endcase
  endfunction
endpackage

// File: rtl/gcd_tag_fifo.sv
// In-order owner-tag FIFO; push is ignored when full and pop when empty.
module gcd_tag_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][W-1:0] r_mem;
  logic [PW-1:0]           r_wr, r_rd;
  logic [CW-1:0]           r_cnt;
  logic                    w_push, w_pop;

  assign full   = (r_cnt == CW'(DEPTH));
  assign empty  = (r_cnt == '0);
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign dout   = r_mem[r_rd];

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    next_ptr = (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= next_ptr(r_wr);
      if (w_pop)  r_rd <= next_ptr(r_rd);
      if (w_push && !w_pop)      r_cnt <= r_cnt + CW'(1);
      else if (w_pop && !w_push) r_cnt <= r_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= din;
  end
endmodule

// File: rtl/gcd_req_arbiter.sv
// Round-robin share of one GcdUnit between two requesters, responses routed by owner tag.
// Optional per-port completion counters under `GCD_ARB_STATS_EN.
module gcd_req_arbiter
  import gcd_arb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_REQ-1:0]                   req_val_i,
  input  logic [NUM_REQ-1:0][GCD_REQ_W-1:0]    req_msg_i,
  output logic [NUM_REQ-1:0]                   req_rdy_o,
  output logic [NUM_REQ-1:0]                   resp_val_o,
  output logic [GCD_RESP_W-1:0]                resp_msg_o,
  input  logic [NUM_REQ-1:0]                   resp_rdy_i,
  output logic                                 gcd_req_val_o,
  output logic [GCD_REQ_W-1:0]                 gcd_req_msg_o,
  input  logic                                 gcd_req_rdy_i,
  input  logic                                 gcd_resp_val_i,
  input  logic [GCD_RESP_W-1:0]                gcd_resp_msg_i,
  output logic                                 gcd_resp_rdy_o,
  output logic [NUM_REQ-1:0][CNT_W-1:0]        done_cnt_o
);
  port_t r_rr;
  port_t w_winner, w_head;
  logic  w_full, w_empty, w_grant_ok, w_push, w_pop;

  assign w_winner      = rr_pick(req_val_i, r_rr);
  assign w_grant_ok    = gcd_req_rdy_i & ~w_full;
  assign gcd_req_val_o = w_grant_ok & (|req_val_i);
  assign gcd_req_msg_o = req_msg_i[w_winner];
  assign w_push        = gcd_req_val_o & gcd_req_rdy_i;

  assign resp_msg_o     = gcd_resp_msg_i;
  assign gcd_resp_rdy_o = ~w_empty & resp_rdy_i[w_head];
  assign w_pop          = gcd_resp_val_i & gcd_resp_rdy_o;

  always_comb begin
    req_rdy_o           = '0;
    req_rdy_o[w_winner] = w_grant_ok;
    resp_val_o          = '0;
    resp_val_o[w_head]  = gcd_resp_val_i & ~w_empty;
  end

  always_ff @(posedge clk) begin
    if (reset)       r_rr <= 1'b0;
    else if (w_push) r_rr <= ~w_winner;
  end

  gcd_tag_fifo #(.DEPTH(DEPTH), .W(1)) u_tags (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_winner),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

`ifdef GCD_ARB_STATS_EN
  logic [NUM_REQ-1:0][CNT_W-1:0] r_done;

  // Saturating: stays at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset)
      r_done <= '0;
    else if (w_pop && (r_done[w_head] != '1))
      r_done[w_head] <= r_done[w_head] + CNT_W'(1);
  end

  assign done_cnt_o = r_done;
`else
  assign done_cnt_o = '0;
`endif
endmodule

// File: tb/tb_gcd_req_arbiter.sv
// Directed bench for gcd_req_arbiter (DEPTH=2, CNT_W=2); bench plays the GcdUnit.
module tb_gcd_req_arbiter;
  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req_val_i;
  logic [1:0][31:0] req_msg_i;
  logic [1:0]       req_rdy_o;
  logic [1:0]       resp_val_o;
  logic [15:0]      resp_msg_o;
  logic [1:0]       resp_rdy_i;
  logic             gcd_req_val_o;
  logic [31:0]      gcd_req_msg_o;
  logic             gcd_req_rdy_i;
  logic             gcd_resp_val_i;
  logic [15:0]      gcd_resp_msg_i;
  logic             gcd_resp_rdy_o;
  logic [1:0][1:0]  done_cnt_o;

  int errs = 0;
  int checks = 0;
  int exp_done [2];

  gcd_req_arbiter #(.DEPTH(2), .CNT_W(2)) dut (
    .clk(clk), .reset(reset),
    .req_val_i(req_val_i), .req_msg_i(req_msg_i), .req_rdy_o(req_rdy_o),
    .resp_val_o(resp_val_o), .resp_msg_o(resp_msg_o), .resp_rdy_i(resp_rdy_i),
    .gcd_req_val_o(gcd_req_val_o), .gcd_req_msg_o(gcd_req_msg_o), .gcd_req_rdy_i(gcd_req_rdy_i),
    .gcd_resp_val_i(gcd_resp_val_i), .gcd_resp_msg_i(gcd_resp_msg_i), .gcd_resp_rdy_o(gcd_resp_rdy_o),
    .done_cnt_o(done_cnt_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected counter value as seen on done_cnt_o for this build.
  function automatic logic [1:0] exp_cnt(input int p);
`ifdef GCD_ARB_STATS_EN
    return 2'(exp_done[p]);
`else
    return 2'd0;
`endif
  endfunction

  task automatic note_done(input int p);
    if (exp_done[p] < 3) exp_done[p]++;
  endtask

  task automatic idle_inputs();
    req_val_i = '0; req_msg_i = '0; resp_rdy_i = '0;
    gcd_req_rdy_i = 1'b0; gcd_resp_val_i = 1'b0; gcd_resp_msg_i = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    exp_done[0] = 0; exp_done[1] = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    step(); step();
    checks++; if (req_rdy_o !== 2'b00) begin errs++; $display("FAIL rst_req_rdy: got %b want 00", req_rdy_o); end
    checks++; if (resp_val_o !== 2'b00) begin errs++; $display("FAIL rst_resp_val: got %b want 00", resp_val_o); end
    checks++; if (gcd_req_val_o !== 1'b0) begin errs++; $display("FAIL rst_gcd_req_val: got %b want 0", gcd_req_val_o); end
    checks++; if (gcd_resp_rdy_o !== 1'b0) begin errs++; $display("FAIL rst_gcd_resp_rdy: got %b want 0", gcd_resp_rdy_o); end
    checks++; if (done_cnt_o !== 4'h0) begin errs++; $display("FAIL rst_done_cnt: got %h want 0", done_cnt_o); end
    reset = 1'b0;
    exp_done[0] = 0; exp_done[1] = 0;
  endtask

  task automatic test_single();
    apply_reset();
    req_val_i = 2'b01; req_msg_i[0] = 32'h000F_0005; gcd_req_rdy_i = 1'b1; resp_rdy_i = 2'b11;
    #1;
    checks++; if (gcd_req_val_o !== 1'b1) begin errs++; $display("FAIL single_gcd_val: got %b want 1", gcd_req_val_o); end
    checks++; if (gcd_req_msg_o !== 32'h000F_0005) begin errs++; $display("FAIL single_gcd_msg: got %h want 000f0005", gcd_req_msg_o); end
    checks++; if (req_rdy_o !== 2'b01) begin errs++; $display("FAIL single_req_rdy: got %b want 01", req_rdy_o); end
    step();
    req_val_i = 2'b00;
    gcd_resp_val_i = 1'b1; gcd_resp_msg_i = 16'h0005;
    #1;
    checks++; if (resp_val_o !== 2'b01) begin errs++; $display("FAIL single_resp_val: got %b want 01", resp_val_o); end
    checks++; if (resp_msg_o !== 16'h0005) begin errs++; $display("FAIL single_resp_msg: got %h want 0005", resp_msg_o); end
    checks++; if (gcd_resp_rdy_o !== 1'b1) begin errs++; $display("FAIL single_gcd_resp_rdy: got %b want 1", gcd_resp_rdy_o); end
    step(); note_done(0);
    #1;
    checks++; if (resp_val_o !== 2'b00) begin errs++; $display("FAIL single_after_pop: got %b want 00", resp_val_o); end
    gcd_resp_val_i = 1'b0;
    checks++; if (done_cnt_o[0] !== exp_cnt(0)) begin errs++; $display("FAIL single_cnt0: got %0d want %0d", done_cnt_o[0], exp_cnt(0)); end
  endtask

  task automatic test_both();
    apply_reset();
    req_val_i = 2'b11; req_msg_i[0] = 32'h000C_0008; req_msg_i[1] = 32'h0015_000E;
    gcd_req_rdy_i = 1'b1; resp_rdy_i = 2'b11;
    #1;
    checks++; if (gcd_req_msg_o !== 32'h000C_0008) begin errs++; $display("FAIL both_first: got %h want 000c0008", gcd_req_msg_o); end
    checks++; if (req_rdy_o !== 2'b01) begin errs++; $display("FAIL both_rdy0: got %b want 01", req_rdy_o); end
    step();
    checks++; if (gcd_req_msg_o !== 32'h0015_000E) begin errs++; $display("FAIL both_second: got %h want 0015000e", gcd_req_msg_o); end
    checks++; if (req_rdy_o !== 2'b10) begin errs++; $display("FAIL both_rdy1: got %b want 10", req_rdy_o); end
    step();
    req_val_i = 2'b00;
    gcd_resp_val_i = 1'b1; gcd_resp_msg_i = 16'h0004;
    #1;
    checks++; if (resp_val_o !== 2'b01 || resp_msg_o !== 16'h0004) begin errs++; $display("FAIL both_resp0: got %b/%h want 01/0004", resp_val_o, resp_msg_o); end
    step(); note_done(0);
    gcd_resp_msg_i = 16'h0007;
    #1;
    checks++; if (resp_val_o !== 2'b10 || resp_msg_o !== 16'h0007) begin errs++; $display("FAIL both_resp1: got %b/%h want 10/0007", resp_val_o, resp_msg_o); end
    step(); note_done(1);
    gcd_resp_val_i = 1'b0;
  endtask

  task automatic test_alternate();
    apply_reset();
    req_val_i = 2'b11; req_msg_i[0] = 32'hAAAA_0000; req_msg_i[1] = 32'hBBBB_0000;
    gcd_req_rdy_i = 1'b1; resp_rdy_i = 2'b11;
    for (int i = 0; i < 6; i++) begin
      gcd_resp_val_i = (i > 0); gcd_resp_msg_i = 16'(i);
      #1;
      checks++;
      if (gcd_req_msg_o !== req_msg_i[i % 2] || req_rdy_o !== (2'b01 << (i % 2))) begin
        errs++; $display("FAIL alt_grant%0d: got %h/%b want %h/%b", i, gcd_req_msg_o, req_rdy_o, req_msg_i[i % 2], 2'b01 << (i % 2));
      end
      if (i > 0) begin
        checks++;
        if (resp_val_o !== (2'b01 << ((i - 1) % 2))) begin
          errs++; $display("FAIL alt_resp%0d: got %b want %b", i, resp_val_o, 2'b01 << ((i - 1) % 2));
        end
      end
      step();
      if (i > 0) note_done((i - 1) % 2);
    end
    req_val_i = 2'b00; gcd_resp_val_i = 1'b1;
    step(); note_done(1);
    gcd_resp_val_i = 1'b0;
    checks++; if (done_cnt_o[0] !== exp_cnt(0) || done_cnt_o[1] !== exp_cnt(1)) begin
      errs++; $display("FAIL alt_cnt: got %0d/%0d want %0d/%0d", done_cnt_o[0], done_cnt_o[1], exp_cnt(0), exp_cnt(1));
    end
  endtask

  task automatic test_full();
    apply_reset();
    gcd_req_rdy_i = 1'b1; resp_rdy_i = 2'b00;
    req_msg_i[0] = 32'h1111_0001; req_msg_i[1] = 32'h2222_0002;
    req_val_i = 2'b01; step();
    req_val_i = 2'b10; step();
    req_val_i = 2'b11;
    #1;
    checks++; if (req_rdy_o !== 2'b00 || gcd_req_val_o !== 1'b0) begin errs++; $display("FAIL full_block: got %b/%b want 00/0", req_rdy_o, gcd_req_val_o); end
    gcd_resp_val_i = 1'b1; gcd_resp_msg_i = 16'h0001;
    #1;
    checks++; if (resp_val_o !== 2'b01 || gcd_resp_rdy_o !== 1'b0) begin errs++; $display("FAIL full_held: got %b/%b want 01/0", resp_val_o, gcd_resp_rdy_o); end
    resp_rdy_i = 2'b01;
    #1;
    checks++; if (gcd_resp_rdy_o !== 1'b1 || req_rdy_o !== 2'b00) begin errs++; $display("FAIL full_pop_no_grant: got %b/%b want 1/00", gcd_resp_rdy_o, req_rdy_o); end
    step(); note_done(0);
    #1;
    checks++; if (req_rdy_o !== 2'b01 || gcd_req_val_o !== 1'b1 || gcd_resp_rdy_o !== 1'b0) begin
      errs++; $display("FAIL full_resume: got %b/%b/%b want 01/1/0", req_rdy_o, gcd_req_val_o, gcd_resp_rdy_o);
    end
    req_val_i = 2'b00; resp_rdy_i = 2'b11; gcd_resp_msg_i = 16'h0002;
    #1;
    checks++; if (resp_val_o !== 2'b10) begin errs++; $display("FAIL full_drain: got %b want 10", resp_val_o); end
    step(); note_done(1);
    gcd_resp_val_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    gcd_req_rdy_i = 1'b1; resp_rdy_i = 2'b11;
    req_val_i = 2'b01; req_msg_i[0] = 32'h0009_0006; step();
    req_val_i = 2'b00;
    reset = 1'b1; step(); reset = 1'b0;
    exp_done[0] = 0; exp_done[1] = 0;
    gcd_resp_val_i = 1'b1; gcd_resp_msg_i = 16'h0003;
    #1;
    checks++; if (resp_val_o !== 2'b00 || gcd_resp_rdy_o !== 1'b0) begin errs++; $display("FAIL rmid_empty: got %b/%b want 00/0", resp_val_o, gcd_resp_rdy_o); end
    step();
    gcd_resp_val_i = 1'b0;
    req_val_i = 2'b11; req_msg_i[1] = 32'h0015_0006;
    #1;
    checks++; if (gcd_req_msg_o !== 32'h0009_0006) begin errs++; $display("FAIL rmid_rr0: got %h want 00090006", gcd_req_msg_o); end
    req_val_i = 2'b10;
    #1;
    checks++; if (req_rdy_o !== 2'b10 || gcd_req_msg_o !== 32'h0015_0006) begin errs++; $display("FAIL rmid_p1: got %b/%h want 10/00150006", req_rdy_o, gcd_req_msg_o); end
    step();
    req_val_i = 2'b00; gcd_resp_val_i = 1'b1; gcd_resp_msg_i = 16'h0003;
    #1;
    checks++; if (resp_val_o !== 2'b10 || resp_msg_o !== 16'h0003) begin errs++; $display("FAIL rmid_route: got %b/%h want 10/0003", resp_val_o, resp_msg_o); end
    step(); note_done(1);
    gcd_resp_val_i = 1'b0;
  endtask

  task automatic test_stats();
    apply_reset();
    gcd_req_rdy_i = 1'b1; resp_rdy_i = 2'b11; req_msg_i[1] = 32'h0004_0002;
    for (int i = 0; i < 5; i++) begin
      req_val_i = 2'b10; step();
      req_val_i = 2'b00; gcd_resp_val_i = 1'b1; gcd_resp_msg_i = 16'h0002;
      step(); note_done(1);
      gcd_resp_val_i = 1'b0;
    end
    #1;
    checks++; if (done_cnt_o[1] !== exp_cnt(1)) begin errs++; $display("FAIL stats_cnt1: got %0d want %0d", done_cnt_o[1], exp_cnt(1)); end
    checks++; if (done_cnt_o[0] !== 2'd0) begin errs++; $display("FAIL stats_cnt0: got %0d want 0", done_cnt_o[0]); end
  endtask

  initial begin
    exp_done[0] = 0; exp_done[1] = 0;
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_single();
    test_both();
    test_alternate();
    test_full();
    test_reset_mid();
    test_stats();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/gcd_req_arbiter.md
# gcd_req_arbiter

Shares a single GcdUnit between two independent requesters: port 0 is the Wishbone-side front end and port 1 is the logic-analyzer-side front end. Requests are granted round-robin onto the GcdUnit request channel. An in-order owner-tag FIFO records which port issued each accepted request. Each GcdUnit response is routed back to the port that issued it. The block sits between the user-project glue logic and the GcdUnit instance.

## Interface
- DEPTH, 2: maximum outstanding accepted-but-unanswered requests (tag FIFO depth, ≥1)
- CNT_W, 16: width of the per-port completion counters (`GCD_ARB_STATS_EN` only)
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_val_i  in  2  per-port request valid
- req_msg_i  in  2×32  per-port request operands; passed through unmodified, not interpreted
- req_rdy_o  out  2  per-port request ready
- resp_val_o  out  2  per-port response valid
- resp_msg_o  out  16  response message, shared by both ports; meaningful only where resp_val_o is set
- resp_rdy_i  in  2  per-port response ready
- gcd_req_val_o  out  1  to GcdUnit req_val
- gcd_req_msg_o  out  32  to GcdUnit req_msg
- gcd_req_rdy_i  in  1  from GcdUnit req_rdy
- gcd_resp_val_i  in  1  from GcdUnit resp_val
- gcd_resp_msg_i  in  16  from GcdUnit resp_msg
- gcd_resp_rdy_o  out  1  to GcdUnit resp_rdy
- done_cnt_o  out  2×CNT_W  per-port completed-response counts

## Operation
**Grant**
- grant_ok = gcd_req_rdy_i & !tag_full.
- One port wins per cycle, chosen combinationally:
  - if only one port is valid, that port wins;
  - if both are valid, the port indicated by rr_ptr wins.
- gcd_req_val_o = grant_ok & |req_val_i.
- gcd_req_msg_o = req_msg_i[winner].
- req_rdy_o[winner] = grant_ok. The losing port's req_rdy_o is 0.

**Request handshake**
- Occurs when gcd_req_val_o & gcd_req_rdy_i.
- The winner index is pushed into the tag FIFO.
- rr_ptr becomes ~winner, so the other port has priority next time.
- With no handshake, rr_ptr holds.

**Response routing**
- head = tag FIFO head.
- resp_val_o[head] = gcd_resp_val_i & !tag_empty. The other bit is 0.
- resp_msg_o = gcd_resp_msg_i.
- gcd_resp_rdy_o = !tag_empty & resp_rdy_i[head].
- A response handshake pops the tag FIFO.

**Boundary conditions**
- tag_full blocks every grant, even when a pop happens in the same cycle. Push occurs only when the FIFO is not full.
- A pop-only cycle on a full FIFO frees one slot for the next cycle.
- Simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
- tag_empty while gcd_resp_val_i is high indicates a protocol error. Nothing is routed, gcd_resp_rdy_o = 0, and no state changes.
- FIFO pointers wrap modulo DEPTH. Count range is 0..DEPTH.

**Reset**
- Clears the FIFO (count 0, pointers 0), sets rr_ptr = 0 (port 0 favoured), and clears the counters.
- A reset during an outstanding request discards its tag. GcdUnit shares the same reset.

## Timing
- Reset values:
  - req_rdy_o = 2'b00 unless gcd_req_rdy_i is high (reset does not force it low, because the FIFO is empty after reset);
  - resp_val_o = 0;
  - gcd_req_val_o = 0 unless req_val_i is set;
  - gcd_resp_rdy_o = 0;
  - done_cnt_o = 0.
- Request path is zero-latency combinational (req_* → gcd_req_*). Response path is also combinational.
- Registered state: rr_ptr, tag FIFO, counters. These update on the clk edge of the handshake.
- Throughput is one grant per cycle when GcdUnit is ready.
- Alternation: both ports continuously valid gives grants 0,1,0,1….

## Configuration
- `GCD_ARB_STATS_EN`, defined:
  - done_cnt_o[p] increments on each response handshake to port p;
  - counters saturate at 2^CNT_W−1 and never wrap.
- Undefined:
  - counter logic is not compiled in;
  - done_cnt_o is tied to 0;
  - port list is unchanged.

## Structure
- Package gcd_arb_pkg holds:
  - NUM_REQ = 2, GCD_REQ_W = 32, GCD_RESP_W = 16;
  - the port index typedef (1 bit).
- Sub-module gcd_tag_fifo:
  - parameters DEPTH and data width;
  - ports push/pop/din/dout/full/empty;
  - synchronous reset.

## Test plan
- Port 0 only, req 0x000F_0005, resp_rdy high → GcdUnit returns 0x0005; resp_val_o = 2'b01, resp_msg_o = 0x0005, port 1 never sees a response.
- Both ports valid from reset, port 0 = 0x000C_0008 and port 1 = 0x0015_000E → port 0 granted first. Responses arrive in order: 0x0004 on port 0, then 0x0007 on port 1.
- Both ports continuously valid for 6 grants → grant sequence 0,1,0,1,0,1; FIFO never exceeds DEPTH.
- DEPTH = 2, hold resp_rdy_i low with 2 requests outstanding → req_rdy_o = 00 even with gcd_req_rdy_i high. Release port 0's resp_rdy → one pop, and a grant resumes the next cycle.
- Reset asserted with 1 outstanding request → next cycle resp_val_o = 00, FIFO empty, rr_ptr = 0. A fresh port 1 request is granted and routed correctly.
- `GCD_ARB_STATS_EN` with CNT_W = 2, 5 completions on port 1 → done_cnt_o[1] = 3 (saturated), done_cnt_o[0] = 0. Without the macro, both read 0.
